seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Recovers the 32-bit hex value shown on the multiplexed 8-digit seven-segment display by watching the segment bus (`LED_out`) and the digit-select bus (`LED_ctrl`). It is the receiving end of the display scan protocol. It sits beside the display driver on the same board clock and feeds the ATM controller and testbenches with a read-back of what the customer actually sees. It captures each digit after its scan dwell has settled, reassembles a full frame, and flags stale scans, illegal glyphs and illegal digit selects.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive identical samples of (`LED_ctrl`, `LED_out`) required before a digit is captured; legal range 1..255.
- `TIMEOUT_CYCLES`, default 50_000_000: cycles without a completed frame before `stale` asserts; legal range ≥ 2.
- `clk` in 1: board clock; every flop is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `LED_out` in 7: segment bus, active-low; bit 6 = a … bit 0 = g.
- `LED_ctrl` in 8: digit select, active-low; `LED_ctrl[i]` low selects digit i, which carries `data[4i+3:4i]`.
- `data_o` out 32: last completed frame.
- `frame_valid` out 1: one-cycle pulse when `data_o` updates.
- `changed` out 1: level, valid with `frame_valid`; 1 if the new frame differs from the previous `data_o`, or if it is the first frame since reset.
- `stale` out 1: level; set on timeout, cleared by the next frame.
- `seg_err` out 1: one-cycle pulse when an illegal glyph is captured.
- `ctrl_err` out 1: one-cycle pulse when a captured `LED_ctrl` has more than one low bit.

## Operation
- **Input sync.** Both buses pass through a 2-flop synchronizer; all logic uses the second stage (`ctrl_s`, `seg_s`).
- **Stability counter.**
  - The counter resets to 0 whenever (`ctrl_s`, `seg_s`) differs from the previous cycle; otherwise it increments, saturating.
  - Capture fires once per dwell, on the cycle the count reaches `SETTLE_CYCLES-1`.
  - A `captured` flag blocks re-capture until the pair changes.
- **Capture.**
  - `ctrl_s` == 8'hFF: blanking, ignored with no error.
  - Exactly one low bit i: decode `seg_s` (active-low, a..g MSB-first). Legal glyphs: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
    - Legal glyph: `shadow[4i+:4]` <= nibble and `mask[i]` <= 1.
    - Any other glyph: `seg_err` pulses and the mask is unchanged.
  - More than one low bit: `ctrl_err` pulses and nothing is stored.
- **Frame completion.**
  - Fires when a capture makes `mask` == 8'hFF. Scan order is irrelevant. A digit re-captured before completion overwrites its nibble.
  - On that edge: `data_o` <= shadow, including the nibble just captured; `frame_valid` = 1; `changed` computed; `mask` <= 0; timeout counter <= 0; `stale` <= 0.
- **Timeout.**
  - The counter increments every cycle.
  - On reaching `TIMEOUT_CYCLES-1` without completion: `stale` <= 1, `mask` <= 0, counter <= 0.
  - If completion and timeout happen on the same cycle, completion wins.
- **Reset.** While `rst` is low: `data_o`=0, `frame_valid`=0, `changed`=0, `stale`=0, `seg_err`=0, `ctrl_err`=0, `mask`=0, shadow=0, counters=0, sync stages=8'hFF/7'h7F, first-frame flag=1. Asserting reset mid-frame discards the partial frame immediately.

## Timing
- Input change on pins to appearance in `ctrl_s`/`seg_s`: 2 cycles.
- Change to capture: 2 + `SETTLE_CYCLES` cycles, provided the pair holds throughout. Dwells shorter than `SETTLE_CYCLES` sampled cycles are never captured.
- `frame_valid`, `changed`, `seg_err` and `ctrl_err` are registered and assert on the capture edge. Pulses last exactly one cycle.
- `data_o` holds between frames. No back-pressure: consumers must sample on `frame_valid`.
- At most one capture per dwell, so at most one error pulse per dwell.

## Test plan
- **Full frame.** Reset, then scan digits 0..7 displaying 0x1234ABCD with a 20-cycle dwell each and `SETTLE_CYCLES`=4. Required: one `frame_valid` pulse 6 cycles after digit 7 starts; `data_o`=0x1234ABCD; `changed`=1; no error pulses.
- **Repeat frame.** Scan the same frame again in order 7..0. Required: `frame_valid` pulses; `changed`=0; `data_o` unchanged.
- **Glitch rejection.**
  - Insert a 2-cycle dwell of digit 3 showing 8 inside an otherwise full scan of 0x00000000. Required: no capture from the glitch; `data_o`=0.
  - Send `LED_ctrl`=8'hFF for 20 cycles. Required: no error and no frame.
- **Illegal inputs.**
  - Drive digit 5 with glyph 1111110. Required: `seg_err` single pulse; no `frame_valid` until digit 5 is rescanned legally.
  - Drive `LED_ctrl`=8'b11110000. Required: `ctrl_err` single pulse.
- **Timeout.** With `TIMEOUT_CYCLES`=100, leave the display static after reset (scan 3 digits, then stop). Required: `stale`=1 at cycle 100 after reset and the mask cleared. A subsequent full frame clears `stale` on its `frame_valid` edge.
- **Reset mid-frame.** After capturing 5 digits, pulse `rst` low for 1 cycle. Required: all outputs read 0 asynchronously. The next frame needs all 8 digits, and the first completed frame reports `changed`=1.

Source files
------------

// File: rtl/seg_scan_decoder_if.sv
// Bundle between a seven-segment scan source and the scan decoder: the
// multiplexed display buses plus the recovered-frame and status outputs.
interface seg_scan_decoder_if;
  logic [6:0]  LED_out;      // segments, active-low, bit 6 = a ... bit 0 = g
  logic [7:0]  LED_ctrl;     // digit select, active-low
  logic [31:0] data_o;       // last completed frame
  logic        frame_valid;  // one-cycle pulse when data_o updates
  logic        changed;      // new frame differs from previous (or is first)
  logic        stale;        // no completed frame within the timeout window
  logic        seg_err;      // illegal glyph captured
  logic        ctrl_err;     // more than one digit selected

  // The display side drives the buses and observes the read-back.
  modport master (
    output LED_out, LED_ctrl,
    input  data_o, frame_valid, changed, stale, seg_err, ctrl_err
  );

  // The decoder watches the buses and reports the recovered frame.
  modport slave (
    input  LED_out, LED_ctrl,
    output data_o, frame_valid, changed, stale, seg_err, ctrl_err
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan decoder: synchronizes the display buses, waits for each
// digit dwell to settle, decodes the glyph and reassembles the 32-bit value.
// Reports frame completion, stale scans, illegal glyphs and illegal selects.
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,   // asynchronous, active-low
  seg_scan_decoder_if.slave  bus
);

  localparam int unsigned    TW          = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  // Synchronizer stages and previous-cycle copy of the settled pair
  logic [7:0] ctrl_s1_q, ctrl_s_q, ctrl_prev_q;
  logic [6:0] seg_s1_q, seg_s_q, seg_prev_q;

  // Dwell tracking
  logic [7:0] stab_cnt_q, stab_cnt_d;
  logic       captured_q, captured_d;

  // Frame assembly and outputs
  logic [7:0]    mask_q, mask_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   data_q, data_d;
  logic          fv_q, fv_d;
  logic          changed_q, changed_d;
  logic          stale_q, stale_d;
  logic          seg_err_q, seg_err_d;
  logic          ctrl_err_q, ctrl_err_d;
  logic          first_q, first_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Combinational helpers
  logic        pair_diff;
  logic        capture;
  logic [7:0]  sel;
  logic        sel_none, sel_one, sel_multi;
  logic [3:0]  glyph_nib;
  logic        glyph_ok;
  logic        cap_legal, cap_seg_err, cap_ctrl_err;
  logic [31:0] shadow_cap;
  logic [7:0]  mask_cap;
  logic        complete;
  logic        timeout;

  // Two-flop synchronizer on both buses, idle values match a blanked display
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_s1_q   <= 8'hFF;
      ctrl_s_q    <= 8'hFF;
      ctrl_prev_q <= 8'hFF;
      seg_s1_q    <= 7'h7F;
      seg_s_q     <= 7'h7F;
      seg_prev_q  <= 7'h7F;
    end else begin
      ctrl_s1_q   <= bus.LED_ctrl;
      ctrl_s_q    <= ctrl_s1_q;
      ctrl_prev_q <= ctrl_s_q;
      seg_s1_q    <= bus.LED_out;
      seg_s_q     <= seg_s1_q;
      seg_prev_q  <= seg_s_q;
    end
  end

  // Stability counter: restarts on any change of the pair, saturates at 255.
  // Capture fires once, when the count for the current sample hits the
  // settle threshold; the captured flag stops re-capture within one dwell.
  always_comb begin
    pair_diff  = (ctrl_s_q != ctrl_prev_q) || (seg_s_q != seg_prev_q);
    stab_cnt_d = 8'd0;
    if (!pair_diff) begin
      stab_cnt_d = (stab_cnt_q == 8'hFF) ? 8'hFF : stab_cnt_q + 8'd1;
    end
    capture    = (stab_cnt_d == SETTLE_LAST) && (pair_diff || !captured_q);
    captured_d = capture || (captured_q && !pair_diff);
  end

  // Digit-select classification: none (blank), exactly one, or several
  always_comb begin
    sel       = ~ctrl_s_q;
    sel_none  = (sel == 8'h00);
    sel_one   = !sel_none && ((sel & (sel - 8'd1)) == 8'h00);
    sel_multi = !sel_none && !sel_one;
  end

  // Glyph decode, active-low segments a..g MSB-first
  always_comb begin
    glyph_nib = 4'h0;
    glyph_ok  = 1'b1;
    case (seg_s_q)
      7'b0000001: glyph_nib = 4'h0;
      7'b1001111: glyph_nib = 4'h1;
      7'b0010010: glyph_nib = 4'h2;
      7'b0000110: glyph_nib = 4'h3;
      7'b1001100: glyph_nib = 4'h4;
      7'b0100100: glyph_nib = 4'h5;
      7'b0100000: glyph_nib = 4'h6;
      7'b0001111: glyph_nib = 4'h7;
      7'b0000000: glyph_nib = 4'h8;
      7'b0000100: glyph_nib = 4'h9;
      7'b0001000: glyph_nib = 4'hA;
      7'b1100000: glyph_nib = 4'hB;
      7'b0110001: glyph_nib = 4'hC;
      7'b1000010: glyph_nib = 4'hD;
      7'b0110000: glyph_nib = 4'hE;
      7'b0111000: glyph_nib = 4'hF;
      default:    glyph_ok  = 1'b0;
    endcase
  end

  // Shadow with the selected digit's nibble replaced; sel is one-hot
  // whenever this value is actually stored.
  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    assign shadow_cap[4*gi +: 4] = sel[gi] ? glyph_nib : shadow_q[4*gi +: 4];
  end

  // Capture classification, completion and timeout detection
  always_comb begin
    cap_legal    = capture && sel_one && glyph_ok;
    cap_seg_err  = capture && sel_one && !glyph_ok;
    cap_ctrl_err = capture && sel_multi;
    mask_cap     = mask_q | sel;
    complete     = cap_legal && (mask_cap == 8'hFF);
    timeout      = (to_cnt_q == TO_LAST);
  end

  // Frame assembly next state; completion takes priority over timeout
  always_comb begin
    mask_d     = mask_q;
    shadow_d   = shadow_q;
    data_d     = data_q;
    changed_d  = changed_q;
    stale_d    = stale_q;
    first_d    = first_q;
    to_cnt_d   = to_cnt_q + TW'(1);
    fv_d       = complete;
    seg_err_d  = cap_seg_err;
    ctrl_err_d = cap_ctrl_err;
    if (cap_legal) begin
      shadow_d = shadow_cap;
    end
    if (complete) begin
      data_d    = shadow_cap;
      changed_d = first_q || (shadow_cap != data_q);
      first_d   = 1'b0;
      mask_d    = 8'h00;
      to_cnt_d  = '0;
      stale_d   = 1'b0;
    end else if (timeout) begin
      stale_d  = 1'b1;
      mask_d   = 8'h00;
      to_cnt_d = '0;
    end else if (cap_legal) begin
      mask_d = mask_cap;
    end
  end

  // Dwell and frame state registers; reset drops any partial frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stab_cnt_q <= 8'd0;
      captured_q <= 1'b0;
      mask_q     <= 8'h00;
      shadow_q   <= 32'h0;
      data_q     <= 32'h0;
      fv_q       <= 1'b0;
      changed_q  <= 1'b0;
      stale_q    <= 1'b0;
      seg_err_q  <= 1'b0;
      ctrl_err_q <= 1'b0;
      first_q    <= 1'b1;
      to_cnt_q   <= '0;
    end else begin
      stab_cnt_q <= stab_cnt_d;
      captured_q <= captured_d;
      mask_q     <= mask_d;
      shadow_q   <= shadow_d;
      data_q     <= data_d;
      fv_q       <= fv_d;
      changed_q  <= changed_d;
      stale_q    <= stale_d;
      seg_err_q  <= seg_err_d;
      ctrl_err_q <= ctrl_err_d;
      first_q    <= first_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign bus.data_o      = data_q;
  assign bus.frame_valid = fv_q;
  assign bus.changed     = changed_q;
  assign bus.stale       = stale_q;
  assign bus.seg_err     = seg_err_q;
  assign bus.ctrl_err    = ctrl_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: one decoder with a short timeout for
// stale detection and one with the default timeout for the frame tests.
module tb_seg_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pin_ctrl;
  logic [6:0] pin_seg;

  int checks = 0;
  int errors = 0;
  int fv_a = 0, se_a = 0, ce_a = 0, fv_t = 0;

  always #5 clk = ~clk;

  seg_scan_decoder_if ifa ();
  seg_scan_decoder_if ift ();

  assign ifa.LED_ctrl = pin_ctrl;
  assign ifa.LED_out  = pin_seg;
  assign ift.LED_ctrl = pin_ctrl;
  assign ift.LED_out  = pin_seg;

  seg_scan_decoder #(.SETTLE_CYCLES(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  seg_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut_t (
    .clk (clk),
    .rst (rst),
    .bus (ift)
  );

  // Pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    if (ifa.frame_valid) fv_a++;
    if (ifa.seg_err)     se_a++;
    if (ifa.ctrl_err)    ce_a++;
    if (ift.frame_valid) fv_t++;
  end

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    case (n)
      4'h0: glyph_of = 7'b0000001;
      4'h1: glyph_of = 7'b1001111;
      4'h2: glyph_of = 7'b0010010;
      4'h3: glyph_of = 7'b0000110;
      4'h4: glyph_of = 7'b1001100;
      4'h5: glyph_of = 7'b0100100;
      4'h6: glyph_of = 7'b0100000;
      4'h7: glyph_of = 7'b0001111;
      4'h8: glyph_of = 7'b0000000;
      4'h9: glyph_of = 7'b0000100;
      4'hA: glyph_of = 7'b0001000;
      4'hB: glyph_of = 7'b1100000;
      4'hC: glyph_of = 7'b0110001;
      4'hD: glyph_of = 7'b1000010;
      4'hE: glyph_of = 7'b0110000;
      default: glyph_of = 7'b0111000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a pair and hold it for n rising edges; returns 1 time unit after the last
  task automatic show(input logic [7:0] c, input logic [6:0] s, input int n);
    pin_ctrl = c;
    pin_seg  = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sel_of(input int d);
    logic [7:0] one;
    one = 8'h01 << d;
    return ~one;
  endfunction

  task automatic scan(input logic [31:0] v, input int first, input int last, input int n);
    for (int d = first; d <= last; d++) show(sel_of(d), glyph_of(v[4*d +: 4]), n);
  endtask

  // Final digit of a frame on dut_a: pulse must appear exactly 6 edges after the drive
  task automatic last_digit_a(input string tag, input int d, input logic [31:0] v,
                              input logic exp_chg, input int n);
    pin_ctrl = sel_of(d);
    pin_seg  = glyph_of(v[4*d +: 4]);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check({tag, "_fv_early"}, ifa.frame_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_fv_pulse"}, ifa.frame_valid, 1);
    check({tag, "_data"}, ifa.data_o, v);
    check({tag, "_changed"}, ifa.changed, exp_chg);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_fv_drop"}, ifa.frame_valid, 0);
    repeat (n - 7) @(posedge clk);
    #1;
  endtask

  initial begin
    pin_ctrl = 8'hFF;
    pin_seg  = 7'h7F;
    rst      = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_data",     ifa.data_o, 0);
    check("rst_fv",       ifa.frame_valid, 0);
    check("rst_changed",  ifa.changed, 0);
    check("rst_stale",    ifa.stale, 0);
    check("rst_seg_err",  ifa.seg_err, 0);
    check("rst_ctrl_err", ifa.ctrl_err, 0);
    check("rst_t_stale",  ift.stale, 0);
    rst = 1'b1;

    // Timeout: 3 digits then a static display; stale lands on edge 100
    scan(32'h1234ABCD, 0, 2, 10);
    show(8'hFF, 7'h7F, 69);
    check("to_stale_99", ift.stale, 0);
    @(posedge clk);
    #1;
    check("to_stale_100",  ift.stale, 1);
    check("to_no_frame",   fv_t, 0);
    check("to_default_ok", ifa.stale, 0);

    // Mask was cleared: digits 3..7 alone must not finish a frame
    scan(32'h1234ABCD, 3, 7, 10);
    check("to_mask_clr", fv_t, 0);
    scan(32'h1234ABCD, 0, 1, 10);
    pin_ctrl = sel_of(2);
    pin_seg  = glyph_of(4'hB);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("to_stale_held", ift.stale, 1);
    check("to_fv_early",   ift.frame_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("to_fv_pulse",   ift.frame_valid, 1);
    check("to_stale_clr",  ift.stale, 0);
    check("to_data",       ift.data_o, 32'h1234ABCD);
    repeat (4) @(posedge clk);
    #1;

    // Clean restart for the frame tests
    pin_ctrl = 8'hFF;
    pin_seg  = 7'h7F;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    show(8'hFF, 7'h7F, 10);
    fv_a = 0;
    se_a = 0;
    ce_a = 0;

    // Full frame, scan order 0..7
    scan(32'h1234ABCD, 0, 6, 20);
    last_digit_a("full", 7, 32'h1234ABCD, 1'b1, 20);
    check("full_fv_cnt", fv_a, 1);
    check("full_seg_err", se_a, 0);
    check("full_ctrl_err", ce_a, 0);

    // Blanking for 20 cycles
    show(8'hFF, 7'h7F, 20);
    check("blank_fv", fv_a, 1);
    check("blank_err", se_a + ce_a, 0);

    // Repeat frame, scan order 7..0
    for (int d = 7; d >= 1; d--) show(sel_of(d), glyph_of(32'h1234ABCD >> (4*d)), 20);
    last_digit_a("repeat", 0, 32'h1234ABCD, 1'b0, 20);
    check("repeat_fv_cnt", fv_a, 2);

    // Glitch: 2-cycle dwell of digit 3 showing 8 must be ignored
    scan(32'h0, 0, 3, 20);
    show(sel_of(3), glyph_of(4'h8), 2);
    scan(32'h0, 4, 6, 20);
    last_digit_a("glitch", 7, 32'h0, 1'b1, 20);
    check("glitch_fv_cnt", fv_a, 3);

    // Illegal glyph on digit 5
    scan(32'hFEDCBA98, 0, 4, 20);
    show(sel_of(5), 7'b1111110, 20);
    check("seg_err_once", se_a, 1);
    scan(32'hFEDCBA98, 6, 7, 20);
    check("seg_err_no_frame", fv_a, 3);
    last_digit_a("rescan5", 5, 32'hFEDCBA98, 1'b1, 20);
    check("rescan_fv_cnt", fv_a, 4);
    check("rescan_seg_err", se_a, 1);

    // Two digits selected at once
    show(8'b11110000, glyph_of(4'h8), 20);
    check("ctrl_err_once", ce_a, 1);
    check("ctrl_err_no_frame", fv_a, 4);
    check("ctrl_err_data", ifa.data_o, 32'hFEDCBA98);

    // Reset mid-frame after 5 captured digits
    scan(32'hFEDCBA98, 0, 4, 20);
    pin_ctrl = 8'hFF;
    pin_seg  = 7'h7F;
    rst = 1'b0;
    #1;
    check("mid_rst_data",    ifa.data_o, 0);
    check("mid_rst_fv",      ifa.frame_valid, 0);
    check("mid_rst_changed", ifa.changed, 0);
    check("mid_rst_errs",    {ifa.seg_err, ifa.ctrl_err, ifa.stale}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    scan(32'h0, 5, 7, 20);
    check("mid_rst_partial", fv_a, 4);
    scan(32'h0, 0, 3, 20);
    last_digit_a("post_rst", 4, 32'h0, 1'b1, 20);
    check("post_rst_fv_cnt", fv_a, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
